// File: rtl/ffo_index_stream_if.sv
// Stream bundle for ffo_index_stream: word input handshake and index output
// handshake. The DUT takes the slave side, the word source / index sink the master side.
interface ffo_index_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [0:4]  out_idx;
  logic        out_last;

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_idx, out_last
  );
endinterface

// File: rtl/ffo_index_stream.sv
// ffo_index_stream: accepts a 32-bit flag word and streams out the index of
// every set bit, lowest index (MSB) first, one per output handshake.
module ffo_index_stream #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  ffo_index_stream_if.slave s,
  output logic             word_done,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [0:WIDTH-1]   word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               zpend_q, zpend_d;

  logic [4:0]         idx;
  logic [0:WIDTH-1]   clr_mask;
  logic [0:WIDTH-1]   word_cleared;
  logic               last;
  logic               busy;
  logic               beat;
  logic               acc;

  // Find-first-one: index of the lowest-numbered (leftmost) set bit.
  function automatic logic [4:0] ffo32(input logic [0:31] v);
    logic [4:0] p;
    p = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[31-i]) p = 5'(31 - i);
    end
    return p;
  endfunction

  // Current index, the word with that bit removed, and the handshake terms.
  always_comb begin
    idx          = ffo32(word_q);
    clr_mask     = {1'b1, {(WIDTH-1){1'b0}}} >> idx;
    word_cleared = word_q & ~clr_mask;
    last         = (word_cleared == '0);
    busy         = (state_q == BUSY);
    beat         = busy & ~flush & s.out_ready;
    acc          = s.in_valid & ~flush & (~busy | (beat & last));
  end

  assign s.out_valid = busy & ~flush;
  assign s.out_idx   = idx;
  assign s.out_last  = busy & last;
  assign s.in_ready  = ~flush & (~busy | (beat & last));
  assign word_done   = done_q;
  assign word_count  = count_q;

  // Next-state logic: consume beats, load new words, schedule word_done.
  // A zero word accepted while the done slot of the next cycle is already
  // taken (last beat of the previous word, or an earlier deferred zero word)
  // is parked in zpend and reported one cycle later.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    count_d = count_q;
    zpend_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      word_d  = '0;
      cnt_d   = '0;
      if (zpend_q) begin
        done_d  = 1'b1;
        count_d = '0;
      end
    end else begin
      if (zpend_q) begin
        done_d  = 1'b1;
        count_d = '0;
      end
      if (beat) begin
        word_d = word_cleared;
        cnt_d  = cnt_q + 1'b1;
        if (last) begin
          done_d  = 1'b1;
          count_d = cnt_q + 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      if (acc) begin
        if (|s.in_word) begin
          state_d = BUSY;
          word_d  = s.in_word;
        end else if (done_d) begin
          zpend_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          count_d = '0;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      count_q <= count_d;
      zpend_q <= zpend_d;
    end
  end

endmodule
